// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: waits WAIT_CYCLES per memory read, registers the fetched word and PC,
// decodes unconditional B for the next fetch address, and supports stall and redirect.
module instruction_fetch_unit #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] IMemAddress,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [63:0] RedirectTarget,
    output logic [31:0] Instruction,
    output logic [63:0] InstrPC,
    output logic        InstrValid
);

    typedef enum logic [0:0] {StFetch, StBlocked} state_e;

    localparam logic [7:0]  LastCnt     = 8'(WAIT_CYCLES - 1);
    localparam logic [63:0] ResetPcAlgn = {RESET_PC[63:2], 2'b00};

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;

    logic        out_free;
    logic        consume;
    logic        capture;
    logic        is_branch;
    logic [63:0] br_offset;
    logic [63:0] next_pc;
    logic [1:0]  unused_target_lsbs;

    assign unused_target_lsbs = RedirectTarget[1:0];

    assign IMemAddress = pc_q;
    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = valid_q;

    assign consume  = valid_q && !Stall;
    assign out_free = !valid_q || !Stall;

    // Opcode 000101 is the unconditional B; its 26-bit word offset is sign-extended.
    assign is_branch = (IMemData[31:26] == 6'b000101);
    assign br_offset = {{36{IMemData[25]}}, IMemData[25:0], 2'b00};
    assign next_pc   = is_branch ? (pc_q + br_offset) : (pc_q + 64'd4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        capture    = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (cnt_q == LastCnt) begin
                    if (out_free) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StBlocked;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StBlocked: begin
                if (out_free) begin
                    capture = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (capture) begin
            instr_d    = IMemData;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = next_pc;
            cnt_d      = 8'd0;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        // Redirect discards any capture due this cycle and flushes the held instruction.
        if (Redirect) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            pc_d       = {RedirectTarget[63:2], 2'b00};
            cnt_d      = 8'd0;
            state_d    = StFetch;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= StFetch;
            pc_q       <= ResetPcAlgn;
            cnt_q      <= 8'd0;
            instr_q    <= 32'h0;
            instr_pc_q <= 64'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle vectors on a WAIT_CYCLES=1 instance and a
// scoreboard of the expected fetch stream on a WAIT_CYCLES=3 instance.
module tb_instruction_fetch_unit;

    localparam logic [31:0] Nop = 32'hD503201F;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [63:0] tgt;
        logic        ev;
        logic [63:0] eaddr;
        logic [63:0] eipc;
        logic [31:0] einstr;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_a, stall_a, redir_a;
    logic [63:0] tgt_a, addr_a, ipc_a;
    logic [31:0] data_a, instr_a;
    logic        valid_a;

    logic        rst_b, stall_b, redir_b;
    logic [63:0] tgt_b, addr_b, ipc_b;
    logic [31:0] data_b, instr_b;
    logic        valid_b;

    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h910003E1;
            64'h4:   return 32'h910007E2;
            64'h8:   return 32'h8B020021;
            64'h10:  return 32'h17FFFFFC;
            64'h100: return 32'h14000002;
            default: return Nop;
        endcase
    endfunction

    function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [31:0] w);
        logic [63:0] words;
        words = {{38{w[25]}}, w[25:0]};
        if (w[31:26] == 6'b000101) return pc + (words << 2);
        return pc + 64'd4;
    endfunction

    assign data_a = mem_rd(addr_a);
    assign data_b = mem_rd(addr_b);

    instruction_fetch_unit #(.WAIT_CYCLES(1), .RESET_PC(64'h0)) dut_a (
        .CLK            (clk),
        .Reset          (rst_a),
        .IMemAddress    (addr_a),
        .IMemData       (data_a),
        .Stall          (stall_a),
        .Redirect       (redir_a),
        .RedirectTarget (tgt_a),
        .Instruction    (instr_a),
        .InstrPC        (ipc_a),
        .InstrValid     (valid_a)
    );

    instruction_fetch_unit #(.WAIT_CYCLES(3), .RESET_PC(64'h8)) dut_b (
        .CLK            (clk),
        .Reset          (rst_b),
        .IMemAddress    (addr_b),
        .IMemData       (data_b),
        .Stall          (stall_b),
        .Redirect       (redir_b),
        .RedirectTarget (tgt_b),
        .Instruction    (instr_b),
        .InstrPC        (ipc_b),
        .InstrValid     (valid_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t   vecs[$];
    fetch_t sb[$];

    initial begin
        fetch_t      f;
        logic [63:0] p;

        rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; tgt_a = '0;
        rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; tgt_b = '0;
        step();
        step();
        chk("reset addr_a", addr_a, 64'h0);
        chk("reset valid_a", 64'(valid_a), 64'h0);
        chk("reset instr_a", 64'(instr_a), 64'h0);
        chk("reset ipc_a", ipc_a, 64'h0);
        chk("reset addr_b", addr_b, 64'h8);
        chk("reset valid_b", 64'(valid_b), 64'h0);

        //            rst   stall redir tgt                    ev    addr                   ipc                    instr
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h4,                 64'h0,                 32'h910003E1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h8,                 64'h4,                 32'h910007E2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'hC,                 64'h8,                 32'h8B020021});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h10,                64'hC,                 Nop});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h0,                 64'h10,                32'h17FFFFFC});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,                1'b1, 64'h0,                 64'h10,                32'h17FFFFFC});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,                1'b1, 64'h0,                 64'h10,                32'h17FFFFFC});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,                1'b1, 64'h0,                 64'h10,                32'h17FFFFFC});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h4,                 64'h0,                 32'h910003E1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h43,               1'b0, 64'h40,                64'h0,                 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h44,                64'h40,                Nop});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h100,              1'b0, 64'h100,               64'h0,                 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h108,               64'h100,               32'h14000002});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFD, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0,                 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h0,                 64'hFFFFFFFFFFFFFFFC, Nop});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h8,                1'b0, 64'h8,                 64'h0,                 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,                1'b1, 64'hC,                 64'h8,                 32'h8B020021});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,                1'b1, 64'hC,                 64'h8,                 32'h8B020021});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 64'h200,              1'b0, 64'h0,                 64'h0,                 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,                1'b1, 64'h4,                 64'h0,                 32'h910003E1});

        foreach (vecs[i]) begin
            rst_a   = vecs[i].rst;
            stall_a = vecs[i].stall;
            redir_a = vecs[i].redir;
            tgt_a   = vecs[i].tgt;
            step();
            chk($sformatf("vec%0d valid", i), 64'(valid_a), 64'(vecs[i].ev));
            chk($sformatf("vec%0d addr", i), addr_a, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d ipc", i), ipc_a, vecs[i].eipc);
                chk($sformatf("vec%0d instr", i), 64'(instr_a), 64'(vecs[i].einstr));
            end
        end
        redir_a = 1'b0;
        stall_a = 1'b0;

        // Expected fetch stream of the three-cycle instance, from its reset PC.
        p = 64'h8;
        for (int n = 0; n < 10; n++) begin
            f.pc    = p;
            f.instr = mem_rd(p);
            sb.push_back(f);
            p = ref_next(p, f.instr);
        end
        rst_b = 1'b0;
        for (int k = 0; k < 27; k++) begin
            step();
            chk($sformatf("w3 cyc%0d valid", k), 64'(valid_b), 64'((k % 3) == 2));
            if (sb.size() < 2) begin
                chk($sformatf("w3 cyc%0d scoreboard depth", k), 64'(sb.size()), 64'd2);
            end else if (valid_b) begin
                f = sb.pop_front();
                chk($sformatf("w3 cyc%0d ipc", k), ipc_b, f.pc);
                chk($sformatf("w3 cyc%0d instr", k), 64'(instr_b), 64'(f.instr));
                chk($sformatf("w3 cyc%0d addr", k), addr_b, sb[0].pc);
            end else begin
                chk($sformatf("w3 cyc%0d held addr", k), addr_b, sb[0].pc);
            end
        end

        // Reset mid-fetch, then the first capture lands three edges after release.
        step();
        rst_b = 1'b1;
        step();
        chk("w3 midreset addr", addr_b, 64'h8);
        chk("w3 midreset valid", 64'(valid_b), 64'h0);
        rst_b = 1'b0;
        step();
        chk("w3 post0 valid", 64'(valid_b), 64'h0);
        step();
        chk("w3 post1 valid", 64'(valid_b), 64'h0);
        step();
        chk("w3 post2 valid", 64'(valid_b), 64'h1);
        chk("w3 post2 ipc", ipc_b, 64'h8);
        chk("w3 post2 addr", addr_b, 64'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, instruction-memory read latency in clocks; legal range 1..255.
REQ-002 Parameter: RESET_PC, default 64'h0, fetch address after reset; bits [1:0] must be 0.
REQ-003 Port: CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: IMemAddress  output  64  address driven to the instruction memory; equals the internal PC.
REQ-006 Port: IMemData  input  32  instruction word returned by the instruction memory.
REQ-007 Port: Stall  input  1  downstream (IF/ID) not ready; blocks consumption of the held instruction.
REQ-008 Port: Redirect  input  1  taken branch from a later stage; flushes and refetches.
REQ-009 Port: RedirectTarget  input  64  new fetch address; valid when Redirect=1.
REQ-010 Port: Instruction  output  32  registered fetched instruction.
REQ-011 Port: InstrPC  output  64  address from which Instruction was fetched.
REQ-012 Port: InstrValid  output  1  Instruction/InstrPC hold an unconsumed instruction.

Function
REQ-013 Internal state: PC (64 b), wait counter cnt (8 b), FSM {FETCH, BLOCKED}, and the output register (Instruction, InstrPC, InstrValid).
REQ-014 IMemAddress SHALL equal PC combinationally at all times; PC[1:0] is always 00.
REQ-015 Consume event: InstrValid=1 and Stall=0 at a clock edge; output free: InstrValid=0 or a consume event.
REQ-016 FETCH: cnt increments each cycle; data is ready when cnt == WAIT_CYCLES-1.
REQ-017 FETCH, data ready, output free: capture IMemData into Instruction, PC into InstrPC, set InstrValid=1, load PC with the next PC, clear cnt to 0, remain in FETCH.
REQ-018 FETCH, data ready, output not free: go to BLOCKED; PC and cnt are held.
REQ-019 BLOCKED: PC is held; on output free, perform the REQ-017 capture and return to FETCH.
REQ-020 Consume event with no capture in the same cycle: InstrValid goes to 0; otherwise Instruction, InstrPC and InstrValid hold.
REQ-021 Next PC: if IMemData[31:26] == 6'b000101 (unconditional B), then PC + (sign-extended IMemData[25:0] << 2); otherwise PC + 4. All arithmetic is modulo 2^64 and wraps silently.
REQ-022 Redirect=1 has priority over all other events in that cycle:
  - PC <= {RedirectTarget[63:2], 2'b00}
  - cnt <= 0, state <= FETCH, InstrValid <= 0
  - any capture due that cycle is discarded
REQ-023 Redirect does not depend on Stall; a stalled instruction is flushed.
REQ-024 With WAIT_CYCLES=1 and Stall=0, the block delivers one instruction per clock with no bubbles.
REQ-025 IMemData is sampled only on the capture cycle; its value on other cycles is ignored, including X.

Reset
REQ-026 While Reset=1 at a clock edge:
  - PC <= RESET_PC, cnt <= 0, state <= FETCH
  - Instruction <= 32'h0, InstrPC <= 64'h0, InstrValid <= 0
REQ-027 Reset has priority over Redirect and Stall, and takes effect mid-fetch or while BLOCKED.
REQ-028 The first fetch starts on the first edge with Reset=0; with WAIT_CYCLES=1, the first InstrValid=1 appears after that edge.

Verification
REQ-029 WAIT_CYCLES=1, memory holding 0x910003E1@0x0, 0x910007E2@0x4, 0x8B020021@0x8 -> InstrPC sequence 0x0, 0x4, 0x8 on consecutive cycles with matching Instruction and InstrValid=1 throughout.
REQ-030 B decode: 0x17FFFFFC@0x10 -> after capture IMemAddress=0x0, InstrPC=0x10. Also 0x14000002@0x0 -> IMemAddress=0x8.
REQ-031 Stall held 3 cycles while InstrValid=1 -> Instruction, InstrPC and IMemAddress are constant and state is BLOCKED; on release, the held instruction is consumed and the next is captured the same edge.
REQ-032 Redirect=1, RedirectTarget=0x43, on a capture cycle -> next cycle InstrValid=0 and IMemAddress=0x40; next capture has InstrPC=0x40.
REQ-033 WAIT_CYCLES=3, Stall=0 -> InstrValid rises every 3rd cycle; PC advances by 4 per capture; no capture on intermediate cycles.
REQ-034 Reset asserted while BLOCKED with Redirect=1 -> next cycle IMemAddress=RESET_PC, InstrValid=0, state FETCH.
